// File: rtl/pcie_tx_pkg.sv
// Shared constants and types for the PCIe TX full_logic VC-to-destination path.
package pcie_tx_pkg;

    localparam int unsigned DATA_WIDTH = 6;
    localparam int unsigned DEST_BIT   = 4;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VC0  = 2'd1,
        VC1  = 2'd2
    } grant_e;

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Handshake bundle between the VC FIFOs, the D FIFOs and the VC-to-destination arbiter.
interface vc_dest_arbiter_if;
    import pcie_tx_pkg::*;

    logic                  i_enable;
    logic                  i_vc0_empty;
    logic                  i_vc1_empty;
    logic [DATA_WIDTH-1:0] i_vc0_data;
    logic [DATA_WIDTH-1:0] i_vc1_data;
    logic                  i_d0_almost_full;
    logic                  i_d1_almost_full;
    logic                  o_vc0_pop;
    logic                  o_vc1_pop;
    logic                  o_d0_push;
    logic                  o_d1_push;
    logic [DATA_WIDTH-1:0] o_d_data_out;
    logic                  o_last_grant;

    modport slave (
        input  i_enable, i_vc0_empty, i_vc1_empty, i_vc0_data, i_vc1_data,
               i_d0_almost_full, i_d1_almost_full,
        output o_vc0_pop, o_vc1_pop, o_d0_push, o_d1_push, o_d_data_out, o_last_grant
    );

    modport master (
        output i_enable, i_vc0_empty, i_vc1_empty, i_vc0_data, i_vc1_data,
               i_d0_almost_full, i_d1_almost_full,
        input  o_vc0_pop, o_vc1_pop, o_d0_push, o_d1_push, o_d_data_out, o_last_grant
    );

endinterface

// File: rtl/vc_starve_counter.sv
// Saturating count of consecutive VC1 denials; at_limit forces the next eligible VC1 grant.
module vc_starve_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inc,
    input  logic       i_clr,
    input  logic [3:0] i_limit,
    output logic       o_at_limit
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && (r_cnt < i_limit)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_at_limit = (r_cnt == i_limit);

endmodule

// File: rtl/vc_dest_arbiter.sv
// Moves at most one VC head word per cycle into the D FIFO named by its routing bit;
// VC0 has priority, VC1 gets a starvation guard and bypasses a blocked VC0 head.
module vc_dest_arbiter
    import pcie_tx_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    vc_dest_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                  w_dest0;
    logic                  w_dest1;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_at_limit;
    grant_e                w_grant;
    logic                  w_vld_p0;
    logic                  w_sel_dest_p0;
    logic [DATA_WIDTH-1:0] w_sel_data_p0;

    logic                  r_d0_push_p1;
    logic                  r_d1_push_p1;
    logic [DATA_WIDTH-1:0] r_d_data_p1;
    logic                  r_last_grant_p1;

    assign w_dest0 = bus.i_vc0_data[DEST_BIT];
    assign w_dest1 = bus.i_vc1_data[DEST_BIT];

    // A head is only eligible if its own destination can take one more word.
    assign w_elig0 = !bus.i_vc0_empty &&
                     !((w_dest0 == DEST_D1) ? bus.i_d1_almost_full : bus.i_d0_almost_full);
    assign w_elig1 = !bus.i_vc1_empty &&
                     !((w_dest1 == DEST_D1) ? bus.i_d1_almost_full : bus.i_d0_almost_full);

    always_comb begin
        w_grant = NONE;
        if (!reset && bus.i_enable) begin
            if (w_at_limit && w_elig1) begin
                w_grant = VC1;
            end else if (w_elig0) begin
                w_grant = VC0;
            end else if (w_elig1) begin
                w_grant = VC1;
            end
        end
    end

    vc_starve_counter u_starve (
        .clk        (clk),
        .reset      (reset),
        .i_inc      ((w_grant == VC0) && w_elig1),
        .i_clr      (w_grant == VC1),
        .i_limit    (LIMIT),
        .o_at_limit (w_at_limit)
    );

    assign bus.o_vc0_pop = (w_grant == VC0);
    assign bus.o_vc1_pop = (w_grant == VC1);

    assign w_vld_p0      = (w_grant != NONE);
    assign w_sel_dest_p0 = (w_grant == VC1) ? w_dest1 : w_dest0;
    assign w_sel_data_p0 = (w_grant == VC1) ? bus.i_vc1_data : bus.i_vc0_data;

    // ---- p0 -> p1: popped word becomes the D FIFO push one cycle later ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0_push_p1    <= 1'b0;
            r_d1_push_p1    <= 1'b0;
            r_d_data_p1     <= '0;
            r_last_grant_p1 <= 1'b0;
        end else begin
            r_d0_push_p1 <= w_vld_p0 && (w_sel_dest_p0 == DEST_D0);
            r_d1_push_p1 <= w_vld_p0 && (w_sel_dest_p0 == DEST_D1);
            if (w_vld_p0) begin
                r_d_data_p1     <= w_sel_data_p0;
                r_last_grant_p1 <= (w_grant == VC1);
            end
        end
    end

    assign bus.o_d0_push    = r_d0_push_p1;
    assign bus.o_d1_push    = r_d1_push_p1;
    assign bus.o_d_data_out = r_d_data_p1;
    assign bus.o_last_grant = r_last_grant_p1;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Vector table plus hand sequences; registered outputs checked through an expectation queue.
module tb_vc_dest_arbiter;

    typedef struct {
        logic       rst;
        logic       en;
        logic       e0;
        logic       e1;
        logic [5:0] d0;
        logic [5:0] d1;
        logic       af0;
        logic       af1;
        logic       p0;
        logic       p1;
    } vec_t;

    typedef struct {
        logic [1:0] push;   // {d1_push, d0_push}
        logic [5:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   vec_no;
    vec_t tbl[$];
    exp_t sbq[$];
    logic [5:0] m_data;
    logic       m_last;

    vc_dest_arbiter_if bus();

    vc_dest_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic en, input logic e0, input logic e1,
                                input logic [5:0] d0, input logic [5:0] d1,
                                input logic af0, input logic af1, input logic p0, input logic p1);
        vec_t v;
        v.rst = rst; v.en = en; v.e0 = e0; v.e1 = e1;
        v.d0 = d0; v.d1 = d1; v.af0 = af0; v.af1 = af1;
        v.p0 = p0; v.p1 = p1;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, vec_no, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset                = v.rst;
        bus.i_enable         = v.en;
        bus.i_vc0_empty      = v.e0;
        bus.i_vc1_empty      = v.e1;
        bus.i_vc0_data       = v.d0;
        bus.i_vc1_data       = v.d1;
        bus.i_d0_almost_full = v.af0;
        bus.i_d1_almost_full = v.af1;
        #1;
        chk("pops", int'({bus.o_vc1_pop, bus.o_vc0_pop}), int'({v.p1, v.p0}));
        // Expected registered result of this cycle, routing bit is bit 4.
        if (v.rst) begin
            e.push = 2'b00; m_data = 6'd0; m_last = 1'b0;
        end else if (v.p0) begin
            e.push = v.d0[4] ? 2'b10 : 2'b01; m_data = v.d0; m_last = 1'b0;
        end else if (v.p1) begin
            e.push = v.d1[4] ? 2'b10 : 2'b01; m_data = v.d1; m_last = 1'b1;
        end else begin
            e.push = 2'b00;
        end
        e.data = m_data;
        e.last = m_last;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sbq_empty", 1, 0);
        end else begin
            got = sbq.pop_front();
            chk("push", int'({bus.o_d1_push, bus.o_d0_push}), int'(got.push));
            chk("data", int'(bus.o_d_data_out), int'(got.data));
            chk("last_grant", int'(bus.o_last_grant), int'(got.last));
        end
        vec_no++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vec_no = 0;
        m_data = 6'd0;
        m_last = 1'b0;
        reset                = 1'b1;
        bus.i_enable         = 1'b0;
        bus.i_vc0_empty      = 1'b1;
        bus.i_vc1_empty      = 1'b1;
        bus.i_vc0_data       = 6'd0;
        bus.i_vc1_data       = 6'd0;
        bus.i_d0_almost_full = 1'b0;
        bus.i_d1_almost_full = 1'b0;

        // Reset with both VCs loaded, release, routing, HOL bypass.
        tbl.push_back(mk(1, 1, 0, 0, 6'b010110, 6'b000101, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'b010110, 6'b000101, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'b000101, 6'b000101, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'b010100, 6'b000101, 0, 1, 0, 1));
        // Starvation: VC0 x4 then VC1, twice.
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, 1, 0, 0, 6'b000001, 6'b010010, 0, 0,
                             logic'(k % 5 != 4), logic'(k % 5 == 4)));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Enable drop after a VC0 pop: counter must hold at 1 through the gap.
        apply(mk(0, 1, 0, 0, 6'b000011, 6'b010111, 0, 0, 1, 0));
        apply(mk(0, 0, 0, 0, 6'b000011, 6'b010111, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 6'b000011, 6'b010111, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 0, 6'b000011, 6'b010111, 0, 0, 1, 0));
        apply(mk(0, 1, 0, 0, 6'b000011, 6'b010111, 0, 0, 0, 1));

        // Full stall with counter at limit: VC1 wins on release, then VC0.
        for (int k = 0; k < 4; k++) apply(mk(0, 1, 0, 0, 6'b011000, 6'b000110, 0, 0, 1, 0));
        for (int k = 0; k < 10; k++) apply(mk(0, 1, 0, 0, 6'b011000, 6'b000110, 1, 1, 0, 0));
        apply(mk(0, 1, 0, 0, 6'b011000, 6'b000110, 0, 0, 0, 1));
        apply(mk(0, 1, 0, 0, 6'b011000, 6'b000110, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 0, 6'b011000, 6'b000110, 1, 1, 0, 0));
        apply(mk(0, 1, 0, 0, 6'b011000, 6'b000110, 0, 0, 1, 0));

        // Bypass when VC0's D0 is full, then idle with both empty.
        apply(mk(0, 1, 0, 0, 6'b000011, 6'b010111, 1, 0, 0, 1));
        apply(mk(0, 1, 1, 1, 6'b000011, 6'b010111, 0, 0, 0, 0));

        // Mid-stream reset clears the counter and the output stage.
        apply(mk(0, 1, 0, 0, 6'b000111, 6'b011111, 0, 0, 1, 0));
        apply(mk(0, 1, 0, 0, 6'b000111, 6'b011111, 0, 0, 1, 0));
        apply(mk(1, 1, 0, 0, 6'b000111, 6'b011111, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) apply(mk(0, 1, 0, 0, 6'b000111, 6'b011111, 0, 0, 1, 0));
        // At limit but VC1 empty: VC0 still served, then VC1 forced.
        apply(mk(0, 1, 0, 1, 6'b000111, 6'b011111, 0, 0, 1, 0));
        apply(mk(0, 1, 0, 0, 6'b000111, 6'b011111, 0, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
